mux_rr_scheduler: RTL and testbench
===================================

Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 31-input, 2-bit-wide select mux between 31 requesters.
- Drives the mux select code and presents a valid/ready handshake to the downstream consumer of the mux output.
- Returns a one-cycle grant pulse to the requester whose data has been consumed.
- Sits directly in front of the mux select input; the mux data path stays outside this block.

Parameters:
- NUM_CH, 31, number of requesters / mux inputs (legal range 2..31).
- SEL_W, 5, width of select code; must satisfy 2**SEL_W > NUM_CH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_CH  per-channel request level; bit i means channel i has data on mux input i.
- out_ready  input  1  downstream accepts the mux output this cycle.
- sel  output  SEL_W  registered mux select code, value range 0..NUM_CH-1.
- out_valid  output  1  registered; mux output at sel is valid.
- grant  output  NUM_CH  one-hot pulse = onehot(sel) when out_valid && out_ready; zero otherwise (combinational from registers and out_ready).
- busy  output  1  high whenever state is GRANT.

Behaviour:
- Reset values:
  - sel=0, out_valid=0, busy=0, grant=0.
  - last-grant pointer ptr=NUM_CH-1, so channel 0 has highest priority after reset.
  - State = IDLE.
- States:
  - IDLE: out_valid=0; sel holds its last value.
  - GRANT: out_valid=1; sel frozen.
- Eligible set: req (ANDed with the mask when the optional feature is enabled).
- Pick rule: first eligible channel searching ptr+1, ptr+2, … modulo NUM_CH, so channel NUM_CH-1 wraps to 0.
- IDLE -> GRANT:
  - Taken when any channel is eligible at edge N.
  - sel=pick and out_valid=1 from cycle N+1 (one-cycle request-to-valid latency).
- GRANT, out_ready=0: hold sel and out_valid. Stall length is unbounded.
- GRANT, out_ready=1 (handshake):
  - ptr<=sel; grant[sel] pulses this cycle.
  - Next pick is evaluated with ptr=current sel and the current eligible set, excluding the just-served channel unless it is the only eligible one.
  - If a channel is picked: stay in GRANT, load the new sel, out_valid stays 1 (back-to-back, no bubble).
  - Otherwise: go to IDLE, out_valid<=0.
- Request dropped while granted: the transaction is sticky. sel and out_valid are held until the handshake; the requester must keep its data stable until grant.
- Request asserted for the same channel during its own grant: served again only after every other eligible channel (fairness).
- Sel codes NUM_CH..2**SEL_W-1 are never driven.
- Reset mid-GRANT: next cycle all outputs return to reset values; the pending transfer is dropped with no grant pulse.
- req and out_ready are sampled only on clk; no combinational path from req to any output.

Optional Feature:
- Macro: MUX_SCHED_MASK_EN.
- When defined:
  - Adds ports mask_we (input 1) and mask_wdata (input NUM_CH).
  - Adds a mask register, reset to all ones; written with mask_wdata when mask_we=1.
  - Eligible = req & mask.
  - Masking the currently granted channel does not abort it; the handshake completes normally.
  - A mask write and a pick in the same cycle: the pick uses the old mask.
- When undefined: mask ports and register are absent; eligible = req.

Decomposition:
- Package mux_sched_pkg holds:
  - NUM_CH_DEF=31 and SEL_W_DEF=5.
  - State encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - A function computing onehot from a select code.
- Sub-module rr_pick: combinational rotate-priority encoder.
  - Inputs: eligible vector, ptr.
  - Outputs: found and idx.
  - Instantiated once in the scheduler.

Test Plan:
- Reset, then req=0 for 5 cycles -> out_valid=0, sel=0, grant=0, busy=0 throughout.
- req[0] and req[5] set at cycle 0, out_ready=1 constant -> cycle 1 sel=0, grant[0]=1; cycle 2 sel=5, grant[5]=1; drop reqs -> cycle 3 out_valid=0.
- All req bits set, out_ready=1 -> sel sequence 0,1,2,…,30,0 with one grant per cycle and no bubble.
- req[30] only, out_ready=0 for 4 cycles then 1 -> sel=30, out_valid held 4 cycles, single grant[30] pulse, ptr wraps so next req[0]&req[29] picks 0.
- req[3] pulses 1 cycle then drops, out_ready=0 for 2 cycles -> sel=3 held, grant[3] on handshake cycle; rst=1 mid-GRANT in a repeat run -> next cycle out_valid=0, sel=0, no grant.
- With MUX_SCHED_MASK_EN: write mask=~(1<<2), req[2]&req[4] set -> only 4 granted; restore mask -> 2 granted next.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared constants and helpers for the round-robin mux scheduler.
// Optional feature macro: MUX_SCHED_MASK_EN (channel mask register).
package mux_sched_pkg;

    localparam int NUM_CH_DEF = 31;
    localparam int SEL_W_DEF  = 5;
    localparam int OH_W       = 2 ** SEL_W_DEF;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    // One-hot decode of a select code, full code-space wide.
    function automatic logic [OH_W-1:0] onehot(
        input logic [SEL_W_DEF-1:0] code
    );
        logic [OH_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_pick.sv
// Rotating-priority encoder: first eligible channel after ptr,
// wrapping modulo NUM_CH; ptr itself is searched last.
module rr_pick
    import mux_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    logic [SEL_W-1:0] cand;

    // Scan ptr+1 .. ptr+NUM_CH, first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = SEL_W'((int'(ptr) + i) % NUM_CH);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler driving a shared mux select with valid/ready.
// Optional feature macro: MUX_SCHED_MASK_EN (adds mask_we/mask_wdata).
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
`ifdef MUX_SCHED_MASK_EN
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_wdata,
`endif
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic [NUM_CH-1:0] grant,
    output logic              busy
);

    logic              state_q;
    logic              state_d;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  pick_ptr;
    logic [NUM_CH-1:0] eligible;
    logic              found;
    logic [SEL_W-1:0]  idx;
    logic              hs;
    logic [OH_W-1:0]   oh;

`ifdef MUX_SCHED_MASK_EN
    logic [NUM_CH-1:0] mask_q;

    // Mask register; a write lands after this cycle's pick.
    always_ff @(posedge clk) begin
        if (rst)
            mask_q <= '1;
        else if (mask_we)
            mask_q <= mask_wdata;
    end

    assign eligible = req & mask_q;
`else
    assign eligible = req;
`endif

    assign hs = (state_q == ST_GRANT) && out_ready;

    // While granting, search from the served channel so it goes last.
    assign pick_ptr = (state_q == ST_GRANT) ? sel_q : ptr_q;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .eligible (eligible),
        .ptr      (pick_ptr),
        .found    (found),
        .idx      (idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: enter on any eligible, leave on a handshake with no successor.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (found) state_d = ST_GRANT;
            ST_GRANT: if (out_ready && !found) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Select code and last-grant pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= '0;
            ptr_q <= SEL_W'(NUM_CH - 1);
        end else begin
            if (state_q == ST_IDLE && found)
                sel_q <= idx;
            if (hs) begin
                ptr_q <= sel_q;
                if (found)
                    sel_q <= idx;
            end
        end
    end

    // Outputs come from registers; grant also qualified by out_ready.
    always_comb begin
        oh        = onehot(SEL_W_DEF'(sel_q));
        sel       = sel_q;
        out_valid = (state_q == ST_GRANT);
        busy      = (state_q == ST_GRANT);
        grant     = hs ? oh[NUM_CH-1:0] : '0;
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Randomised self-checking bench for mux_rr_scheduler.
// Build with +define+MUX_SCHED_MASK_EN to cover the mask feature.
module tb_mux_rr_scheduler;

    localparam int N  = 31;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          out_ready;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic [SW-1:0] sel;
    logic          out_valid;
    logic [N-1:0]  grant;
    logic          busy;

    int errors = 0;
    int checks = 0;

    int           m_sel;
    int           m_ptr;
    bit           m_valid;
    logic [N-1:0] m_mask;

    always #5 clk = ~clk;

    mux_rr_scheduler #(
        .NUM_CH (N),
        .SEL_W  (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .out_ready  (out_ready),
`ifdef MUX_SCHED_MASK_EN
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
`endif
        .sel        (sel),
        .out_valid  (out_valid),
        .grant      (grant),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Next channel after p (mod N) with its eligible bit set, or -1.
    function automatic int pick(input logic [N-1:0] e, input int p);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (p + k) % N;
            if (e[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_sel   = 0;
        m_valid = 0;
        m_ptr   = N - 1;
        m_mask  = '1;
    endtask

    // Drive one cycle of inputs, check outputs, advance the model.
    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic rdy, input logic mwe = 1'b0,
                        input logic [N-1:0] mwd = '1);
        logic [63:0]  g;
        logic [N-1:0] e;
        int           p;
        @(negedge clk);
        rst        = r;
        req        = rq;
        out_ready  = rdy;
        mask_we    = mwe;
        mask_wdata = mwd;
        #1;
        g = '0;
        if (m_valid && rdy) g = 64'd1 << m_sel;
        check("sel", 64'(sel), 64'(m_sel));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("busy", 64'(busy), 64'(m_valid));
        check("grant", 64'(grant), g);
        if (r) begin
            model_reset();
        end else begin
            e = rq & m_mask;
            if (!m_valid) begin
                p = pick(e, m_ptr);
                if (p >= 0) begin
                    m_valid = 1;
                    m_sel   = p;
                end
            end else if (rdy) begin
                m_ptr = m_sel;
                p = pick(e, m_sel);
                if (p >= 0) m_sel = p;
                else m_valid = 0;
            end
`ifdef MUX_SCHED_MASK_EN
            if (mwe) m_mask = mwd;
`endif
        end
    endtask

    initial begin
        logic [N-1:0] rq;
        logic         rdy;
        logic         r;
        rst        = 1'b1;
        req        = '0;
        out_ready  = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = '1;
        model_reset();
        repeat (2) @(posedge clk);

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1);
            check("idle_valid", 64'(out_valid), 64'd0);
        end

        // Two requesters, back-to-back.
        step(1'b0, N'(32'h21), 1'b1);
        step(1'b0, N'(32'h21), 1'b1);
        check("pair_sel0", 64'(sel), 64'd0);
        check("pair_gnt0", 64'(grant), 64'h1);
        step(1'b0, '0, 1'b1);
        check("pair_sel5", 64'(sel), 64'd5);
        check("pair_gnt5", 64'(grant), 64'h20);
        step(1'b0, '0, 1'b1);
        check("pair_idle", 64'(out_valid), 64'd0);

        // Everyone requests: full rotation with wrap.
        step(1'b1, '0, 1'b0);
        for (int i = 0; i < 33; i++) begin
            step(1'b0, '1, 1'b1);
            if (i > 0) check("rr_seq", 64'(sel), 64'((i - 1) % N));
        end

        // Top channel stalled, then pointer wrap.
        step(1'b1, '0, 1'b0);
        step(1'b0, N'(1) << 30, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, N'(1) << 30, 1'b0);
            check("stall_sel", 64'(sel), 64'd30);
        end
        step(1'b0, '0, 1'b1);
        check("stall_gnt", 64'(grant), 64'h4000_0000);
        step(1'b0, (N'(1) << 29) | N'(1), 1'b0);
        step(1'b0, (N'(1) << 29) | N'(1), 1'b1);
        check("wrap_sel", 64'(sel), 64'd0);

        // Sticky grant after a one-cycle request pulse.
        step(1'b1, '0, 1'b0);
        step(1'b0, N'(8), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("sticky_sel", 64'(sel), 64'd3);
        step(1'b0, '0, 1'b1);
        check("sticky_gnt", 64'(grant), 64'h8);

        // Reset in the middle of a grant.
        step(1'b0, N'(8), 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_gnt", 64'(grant), 64'd0);

`ifdef MUX_SCHED_MASK_EN
        // Masked channel skipped until the mask is restored.
        step(1'b0, '0, 1'b0, 1'b1, ~(N'(1) << 2));
        step(1'b0, N'(32'h14), 1'b0);
        step(1'b0, N'(32'h14), 1'b0, 1'b1, '1);
        check("mask_sel4", 64'(sel), 64'd4);
        step(1'b0, N'(32'h14), 1'b1);
        check("mask_gnt4", 64'(grant), 64'h10);
        step(1'b0, N'(32'h14), 1'b1);
        check("mask_sel2", 64'(sel), 64'd2);
        step(1'b1, '0, 1'b0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       rq = '0;
                1:       rq = N'(1) << $urandom_range(0, N - 1);
                2:       rq = N'($urandom);
                default: rq = '1;
            endcase
            rdy = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 63) == 0);
            if (r) rdy = 1'b0;
            step(r, rq, rdy, ($urandom_range(0, 15) == 0), N'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
